// File: rtl/sram_dp_ctrl.sv
// Simple-dual-port SRAM with byte strobes, pipelined read latency and a post-reset clear sequencer.
// Optional per-lane even parity is enabled by defining SRAM_PARITY_EN.
module sram_dp_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_done,
  input  logic                wr,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                inj_perr,
  input  logic                rd,
  input  logic [ADDR_W-1:0]   raddr,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                perr,
  output logic [7:0]          rej_cnt
);
  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              run;
  logic              rd_en;
  logic [DATA_W-1:0] rd_word;
  logic              rd_bad;

  logic              vld_q [RD_LAT];
  logic [DATA_W-1:0] dat_q [RD_LAT];
  logic              bad_q [RD_LAT];

  assign run   = (state == S_RUN);
  assign rd_en = run & rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_INIT;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (!run) clr_ptr <= clr_ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    init_done = 1'b0;
    case (state)
      S_INIT:  if (clr_ptr == '1) state_nxt = S_RUN;
      S_RUN:   init_done = 1'b1;
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rej_cnt <= '0;
    end else if (!run && (rd || wr) && rej_cnt != 8'hFF) begin
      rej_cnt <= rej_cnt + 8'd1;
    end
  end

  // Write-first: a same-cycle write to the read address is merged lane by lane.
  always_comb begin
    rd_word = mem[raddr];
    if (wr && waddr == raddr) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wstrb[i]) rd_word[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

`ifdef SRAM_PARITY_EN
  logic [LANES-1:0] par_mem [DEPTH];
  logic [LANES-1:0] rd_par;

  always_ff @(posedge clk) begin
    if (!run) begin
      par_mem[clr_ptr] <= '0;
    end else if (wr) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wstrb[i]) par_mem[waddr][i] <= (^wdata[8*i +: 8]) ^ inj_perr;
      end
    end
  end

  always_comb begin
    rd_par = par_mem[raddr];
    if (wr && waddr == raddr) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wstrb[i]) rd_par[i] = (^wdata[8*i +: 8]) ^ inj_perr;
      end
    end
    rd_bad = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if ((^rd_word[8*i +: 8]) != rd_par[i]) rd_bad = 1'b1;
    end
  end
`else
  logic unused_inj;
  assign unused_inj = inj_perr;
  assign rd_bad     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!run) begin
      mem[clr_ptr] <= '0;
    end else if (wr) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Data stages only advance with a valid token, so rdata holds between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < RD_LAT; k++) begin
        vld_q[k] <= 1'b0;
        dat_q[k] <= '0;
        bad_q[k] <= 1'b0;
      end
    end else begin
      vld_q[0] <= rd_en;
      if (rd_en) begin
        dat_q[0] <= rd_word;
        bad_q[0] <= rd_bad;
      end
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_q[k] <= dat_q[k-1];
          bad_q[k] <= bad_q[k-1];
        end
      end
    end
  end

  assign rvalid = vld_q[RD_LAT-1];
  assign rdata  = dat_q[RD_LAT-1];
  assign perr   = vld_q[RD_LAT-1] & bad_q[RD_LAT-1];

endmodule

// File: tb/tb_sram_dp_ctrl.sv
// Directed bench for sram_dp_ctrl: three instances cover 8-bit/RD_LAT=1, 16-bit/RD_LAT=3
// and 8-bit/RD_LAT=2 (reset during an in-flight read).
module tb_sram_dp_ctrl;
`ifdef SRAM_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: DATA_W=8, RD_LAT=1
  logic       rst_a, wr_a, strb_a, inj_a, rd_a, init_a, rvalid_a, perr_a;
  logic [3:0] waddr_a, raddr_a;
  logic [7:0] wdata_a, rdata_a, rej_a;

  sram_dp_ctrl #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst_a), .init_done(init_a), .wr(wr_a), .wstrb(strb_a),
    .waddr(waddr_a), .wdata(wdata_a), .inj_perr(inj_a), .rd(rd_a), .raddr(raddr_a),
    .rvalid(rvalid_a), .rdata(rdata_a), .perr(perr_a), .rej_cnt(rej_a));

  // Instance B: DATA_W=16, RD_LAT=3
  logic        rst_b, wr_b, inj_b, rd_b, init_b, rvalid_b, perr_b;
  logic [1:0]  strb_b;
  logic [3:0]  waddr_b, raddr_b;
  logic [15:0] wdata_b, rdata_b;
  logic [7:0]  rej_b;

  sram_dp_ctrl #(.DATA_W(16), .ADDR_W(4), .RD_LAT(3)) u_b (
    .clk(clk), .rst(rst_b), .init_done(init_b), .wr(wr_b), .wstrb(strb_b),
    .waddr(waddr_b), .wdata(wdata_b), .inj_perr(inj_b), .rd(rd_b), .raddr(raddr_b),
    .rvalid(rvalid_b), .rdata(rdata_b), .perr(perr_b), .rej_cnt(rej_b));

  // Instance C: DATA_W=8, RD_LAT=2
  logic       rst_c, wr_c, strb_c, inj_c, rd_c, init_c, rvalid_c, perr_c;
  logic [3:0] waddr_c, raddr_c;
  logic [7:0] wdata_c, rdata_c, rej_c;

  sram_dp_ctrl #(.DATA_W(8), .ADDR_W(4), .RD_LAT(2)) u_c (
    .clk(clk), .rst(rst_c), .init_done(init_c), .wr(wr_c), .wstrb(strb_c),
    .waddr(waddr_c), .wdata(wdata_c), .inj_perr(inj_c), .rd(rd_c), .raddr(raddr_c),
    .rvalid(rvalid_c), .rdata(rdata_c), .perr(perr_c), .rej_cnt(rej_c));

  typedef struct {
    logic       wr;
    logic       strb;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic       inj;
    logic       rd;
    logic [3:0] raddr;
    logic       xv;
    logic [7:0] xd;
    logic       xp;
  } vec_t;

  vec_t tab [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int pulses;
    logic [15:0] exp_b [4];
    logic [3:0]  ra_b [4];
    int          cyc_b [4];
    logic [15:0] dat_b [4];

    tab[0]  = '{1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, 4'd0,  1'b0, 8'h00, 1'b0};
    tab[1]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd3,  1'b1, 8'hA5, 1'b0};
    tab[2]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0,  1'b0, 8'hA5, 1'b0};
    tab[3]  = '{1'b1, 1'b1, 4'd5, 8'h3C, 1'b0, 1'b1, 4'd5,  1'b1, 8'h3C, 1'b0};
    tab[4]  = '{1'b1, 1'b0, 4'd6, 8'h77, 1'b0, 1'b1, 4'd6,  1'b1, 8'h00, 1'b0};
    tab[5]  = '{1'b1, 1'b1, 4'd7, 8'h5A, 1'b1, 1'b0, 4'd0,  1'b0, 8'h00, 1'b0};
    tab[6]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd7,  1'b1, 8'h5A, PAR };
    tab[7]  = '{1'b1, 1'b1, 4'd7, 8'h5A, 1'b0, 1'b0, 4'd0,  1'b0, 8'h5A, 1'b0};
    tab[8]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd7,  1'b1, 8'h5A, 1'b0};
    tab[9]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd3,  1'b1, 8'hA5, 1'b0};
    tab[10] = '{1'b1, 1'b1, 4'd6, 8'hC3, 1'b1, 1'b1, 4'd6,  1'b1, 8'hC3, PAR };

    {rst_a, wr_a, strb_a, inj_a, rd_a, waddr_a, raddr_a, wdata_a} = '0;
    {rst_b, wr_b, strb_b, inj_b, rd_b, waddr_b, raddr_b, wdata_b} = '0;
    {rst_c, wr_c, strb_c, inj_c, rd_c, waddr_c, raddr_c, wdata_c} = '0;

    repeat (2) tick();
    chk("rst_init_done", 32'(init_a), 32'd0);
    chk("rst_rvalid",    32'(rvalid_a), 32'd0);
    chk("rst_rdata",     32'(rdata_a), 32'd0);
    chk("rst_perr",      32'(perr_a), 32'd0);
    chk("rst_rej_cnt",   32'(rej_a), 32'd0);

    // A: release reset with a write held for 3 cycles during INIT
    @(negedge clk);
    rst_a = 1'b1; wr_a = 1'b1; strb_a = 1'b1; waddr_a = 4'd3; wdata_a = 8'hFF;
    edges = 0;
    for (int e = 1; e <= 40 && edges == 0; e++) begin
      tick();
      if (init_a) edges = e;
      if (e == 3) wr_a = 1'b0;
    end
    chk("a_init_edges", 32'(edges), 32'd16);
    chk("a_rej_cnt",    32'(rej_a), 32'd3);

    for (int a = 0; a < 16; a++) begin
      rd_a = 1'b1; raddr_a = 4'(a);
      tick();
      chk("a_clear_rvalid", 32'(rvalid_a), 32'd1);
      chk("a_clear_rdata",  32'(rdata_a), 32'd0);
    end

    for (int i = 0; i < 11; i++) begin
      wr_a = tab[i].wr; strb_a = tab[i].strb; waddr_a = tab[i].waddr;
      wdata_a = tab[i].wdata; inj_a = tab[i].inj; rd_a = tab[i].rd; raddr_a = tab[i].raddr;
      tick();
      chk($sformatf("vec%0d_rvalid", i), 32'(rvalid_a), 32'(tab[i].xv));
      chk($sformatf("vec%0d_rdata", i),  32'(rdata_a),  32'(tab[i].xd));
      chk($sformatf("vec%0d_perr", i),   32'(perr_a),   32'(tab[i].xp));
    end
    {wr_a, rd_a, inj_a} = '0;

    // B: 16-bit lanes, RD_LAT=3 back-to-back reads
    rst_b = 1'b1;
    edges = 0;
    for (int e = 1; e <= 40 && edges == 0; e++) begin
      tick();
      if (init_b) edges = e;
    end
    chk("b_init_edges", 32'(edges), 32'd16);

    wr_b = 1'b1;
    strb_b = 2'b11; waddr_b = 4'd2; wdata_b = 16'h1234; tick();
    strb_b = 2'b10; waddr_b = 4'd2; wdata_b = 16'hAB00; tick();
    strb_b = 2'b11; waddr_b = 4'd1; wdata_b = 16'h1111; tick();
    strb_b = 2'b01; waddr_b = 4'd0; wdata_b = 16'h0F0F; tick();
    wr_b = 1'b0;
    chk("b_idle_rvalid", 32'(rvalid_b), 32'd0);

    ra_b[0] = 4'd2; ra_b[1] = 4'd1; ra_b[2] = 4'd0; ra_b[3] = 4'd3;
    exp_b[0] = 16'hAB34; exp_b[1] = 16'h1111; exp_b[2] = 16'h000F; exp_b[3] = 16'h0000;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      rd_b = (c < 4);
      raddr_b = (c < 4) ? ra_b[c] : 4'd0;
      tick();
      if (rvalid_b) begin
        if (pulses < 4) begin
          cyc_b[pulses] = c;
          dat_b[pulses] = rdata_b;
        end
        pulses++;
      end
    end
    chk("b_pulse_count", 32'(pulses), 32'd4);
    for (int k = 0; k < 4 && k < pulses; k++) begin
      chk($sformatf("b_pulse%0d_cycle", k), 32'(cyc_b[k]), 32'(k + 2));
      chk($sformatf("b_pulse%0d_rdata", k), 32'(dat_b[k]), 32'(exp_b[k]));
    end
    chk("b_hold_rdata", 32'(rdata_b), 32'h0000);

    // C: rd+wr together count once per cycle; reset mid-read drops the read
    rst_c = 1'b1; rd_c = 1'b1; wr_c = 1'b1; strb_c = 1'b1;
    edges = 0;
    for (int e = 1; e <= 40 && edges == 0; e++) begin
      tick();
      if (init_c) edges = e;
      if (e == 2) begin rd_c = 1'b0; wr_c = 1'b0; end
    end
    chk("c_init_edges", 32'(edges), 32'd16);
    chk("c_rej_cnt",    32'(rej_c), 32'd2);

    rd_c = 1'b1; raddr_c = 4'd0;
    tick();
    rd_c = 1'b0;
    chk("c_rvalid_before", 32'(rvalid_c), 32'd0);
    #2 rst_c = 1'b0;
    #1;
    chk("c_rst_rvalid",   32'(rvalid_c), 32'd0);
    chk("c_rst_rej_cnt",  32'(rej_c), 32'd0);
    chk("c_rst_init",     32'(init_c), 32'd0);
    tick();
    chk("c_dropped_rvalid", 32'(rvalid_c), 32'd0);
    @(negedge clk);
    rst_c = 1'b1;
    edges = 0;
    pulses = 0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (rvalid_c) pulses++;
      if (init_c && edges == 0) edges = e;
    end
    chk("c_no_rvalid",   32'(pulses), 32'd0);
    chk("c_reinit_edges", 32'(edges), 32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
